// File: rtl/serial_mag_compare_ctrl_pkg.sv
// Shared types and constants for the serial magnitude compare sequencer.
// Holds the FSM encoding, nibble width and result-flag bit positions.
package serial_mag_compare_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    localparam int RES_ALB = 0;
    localparam int RES_AEB = 1;
    localparam int RES_AGB = 2;
    localparam int RES_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    function automatic logic [RES_W-1:0] res_onehot(input int pos);
        logic [RES_W-1:0] r;
        r      = '0;
        r[pos] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/nibble_mag_cmp.sv
// Combinational 4-bit unsigned magnitude comparator slice.
// Same function as a 7485 with the cascade inputs tied to "equal".
module nibble_mag_cmp
    import serial_mag_compare_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    output logic                alb,
    output logic                aeb,
    output logic                agb
);

    logic [NIBBLE_W-1:0] x;

    // x[i] is high when bit i of both operands agrees
    assign x = ~(a ^ b);

    assign agb = (a[3] & ~b[3])
               | (x[3] & a[2] & ~b[2])
               | (x[3] & x[2] & a[1] & ~b[1])
               | (x[3] & x[2] & x[1] & a[0] & ~b[0]);

    assign alb = (~a[3] & b[3])
               | (x[3] & ~a[2] & b[2])
               | (x[3] & x[2] & ~a[1] & b[1])
               | (x[3] & x[2] & x[1] & ~a[0] & b[0]);

    assign aeb = &x;

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Wide unsigned compare done one nibble per cycle, MSB first,
// on a single shared comparator slice with early exit.
module serial_mag_compare_ctrl
    import serial_mag_compare_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             alb,
    output logic             aeb,
    output logic             agb
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IW      = $clog2(NIBBLES);

    state_e state_q;
    state_e state_d;

    logic [NIBBLES-1:0][NIBBLE_W-1:0] ra_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] rb_q;

    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    idx_d;
    logic [RES_W-1:0] res_q;
    logic [RES_W-1:0] res_d;
    logic             load;

    logic cmp_lt;
    logic cmp_eq;
    logic cmp_gt;
    logic last;

    nibble_mag_cmp u_cmp (
        .a   (ra_q[idx_q]),
        .b   (rb_q[idx_q]),
        .alb (cmp_lt),
        .aeb (cmp_eq),
        .agb (cmp_gt)
    );

    assign last = (idx_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            res_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            if (load) begin
                ra_q <= a;
                rb_q <= b;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        res_d   = res_q;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    idx_d   = IW'(NIBBLES - 1);
                    res_d   = '0;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                // first unequal nibble decides; equal walks toward LSB
                unique case (1'b1)
                    cmp_gt: begin
                        res_d   = res_onehot(RES_AGB);
                        state_d = S_DONE;
                    end
                    cmp_lt: begin
                        res_d   = res_onehot(RES_ALB);
                        state_d = S_DONE;
                    end
                    (cmp_eq && last): begin
                        res_d   = res_onehot(RES_AEB);
                        state_d = S_DONE;
                    end
                    default: begin
                        idx_d = idx_q - 1'b1;
                    end
                endcase
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q == S_COMPARE);
    assign done = (state_q == S_DONE);
    assign alb  = res_q[RES_ALB];
    assign aeb  = res_q[RES_AEB];
    assign agb  = res_q[RES_AGB];

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Self-checking bench for serial_mag_compare_ctrl: directed cases plus
// randomized compares checked against a cycle-level arithmetic model.
module tb_serial_mag_compare_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             alb;
    logic             aeb;
    logic             agb;

    int total;
    int bad;

    serial_mag_compare_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .alb   (alb),
        .aeb   (aeb),
        .agb   (agb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // nibbles examined: MSB first up to and including first difference
    function automatic int steps(input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y);
        int k;
        k = 0;
        for (int i = NIB - 1; i >= 0; i--) begin
            k++;
            if (((x >> (4 * i)) & 16'hF) != ((y >> (4 * i)) & 16'hF))
                return k;
        end
        return k;
    endfunction

    function automatic logic [2:0] flags(input logic [WIDTH-1:0] x,
                                         input logic [WIDTH-1:0] y);
        return {x < y, x == y, x > y};
    endfunction

    // called at a negedge with the DUT idle; returns at the negedge of
    // the idle cycle after done, so a following call is back-to-back
    task automatic do_cmp(input logic [WIDTH-1:0] ta,
                          input logic [WIDTH-1:0] tb_v,
                          input bit noise);
        int k;
        logic [2:0] ef;
        k  = steps(ta, tb_v);
        ef = flags(ta, tb_v);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= k + 1; c++) begin
            @(negedge clk);
            check("busy", 32'(busy), 32'(c <= k));
            check("done", 32'(done), 32'(c == k + 1));
            check("res", 32'({alb, aeb, agb}), 32'((c <= k) ? 3'b000 : ef));
            if (noise) begin
                start = 1'($urandom);
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("hold", 32'({alb, aeb, agb}), 32'(ef));
    endtask

    initial begin
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", 32'({alb, aeb, agb}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_cmp(16'h8000, 16'h7FFF, 1'b0);
        do_cmp(16'h0000, 16'hFFFF, 1'b0);
        do_cmp(16'h1234, 16'h1234, 1'b0);
        do_cmp(16'h1233, 16'h1234, 1'b0);
        do_cmp(16'h1334, 16'h1234, 1'b0);
        do_cmp(16'h0001, 16'h0000, 1'b1);

        // abort an equal compare with reset at cycle 2
        a     = 16'h1234;
        b     = 16'h1234;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("pre_abort_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_res", 32'({alb, aeb, agb}), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("abort_nodone", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        do_cmp(16'hABCD, 16'hABCE, 1'b0);

        repeat (60) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("gap_busy", 32'(busy), 32'd0);
            end
            y = WIDTH'($urandom);
            x = y;
            if ($urandom_range(0, 3) != 0) begin
                int n;
                n = $urandom_range(0, NIB - 1);
                x[4*n +: 4] = 4'($urandom);
            end else begin
                x = WIDTH'($urandom);
            end
            do_cmp(x, y, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
